// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared FSM encoding and phase-length helpers for clk_div_prog
// Honours CLK_DIV_ODD50_EN (odd ratios split short-high/long-low for the half-cycle stretch).
package clk_div_pkg;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_HIGH_ENC = 2'd1;
    localparam logic [1:0] ST_LOW_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_HIGH = ST_HIGH_ENC,
        ST_LOW  = ST_LOW_ENC
    } state_t;

    localparam int MIN_DIV = 2;

`ifdef CLK_DIV_ODD50_EN
    localparam bit ODD50 = 1'b1;
`else
    localparam bit ODD50 = 1'b0;
`endif

    // LOW always takes the remainder so the period is exactly N in both variants.
    function automatic logic [31:0] phase_high(input logic [31:0] n, input bit odd50);
        return odd50 ? (n >> 1) : (n - (n >> 1));
    endfunction

    function automatic logic [31:0] phase_low(input logic [31:0] n, input bit odd50);
        return n - phase_high(n, odd50);
    endfunction

endpackage

// File: rtl/clk_div_phase_cnt.sv
// rtl/clk_div_phase_cnt.sv - loadable down-counter with terminal-count flag
module clk_div_phase_cnt #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             tc
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable integer clock divider
// CLK_DIV_ODD50_EN adds a negedge stretch flop giving 50 % duty on odd ratios.
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             clk_out,
    output logic             tick,
    output logic             div_pending,
    output logic             load_err
);

    state_t           state;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic [DIV_W-1:0] n_next;
    logic [DIV_W-1:0] cnt_val;
    logic             cnt_tc;
    logic             cnt_load;
    logic             boundary;
    logic             load_ok;
    logic             first_q;
    logic             hi_q;

    assign load_ok = div_load && (div_in >= DIV_W'(MIN_DIV));

    // A boundary is any entry into HIGH; that is the only point the divisor may change.
    always_comb begin
        boundary = en && ((state == ST_IDLE) || ((state == ST_LOW) && cnt_tc));
        n_next   = div_pending ? div_pend : div_act;
        cnt_load = boundary || ((state == ST_HIGH) && cnt_tc);
        if (boundary) begin
            cnt_val = DIV_W'(phase_high(32'(n_next), ODD50) - 32'd1);
        end else begin
            cnt_val = DIV_W'(phase_low(32'(div_act), ODD50) - 32'd1);
        end
    end

    clk_div_phase_cnt #(
        .DIV_W(DIV_W)
    ) u_phase_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .tc       (cnt_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            div_act     <= DIV_W'(DIV_DEFAULT);
            div_pend    <= DIV_W'(DIV_DEFAULT);
            div_pending <= 1'b0;
            first_q     <= 1'b0;
            hi_q        <= 1'b0;
            tick        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            hi_q     <= (state == ST_HIGH);
            tick     <= first_q;
            first_q  <= boundary;
            load_err <= div_load && !load_ok;

            case (state)
                ST_IDLE: if (en)     state <= ST_HIGH;
                ST_HIGH: if (cnt_tc) state <= ST_LOW;
                ST_LOW:  if (cnt_tc) state <= en ? ST_HIGH : ST_IDLE;
                default:             state <= ST_IDLE;
            endcase

            if (boundary && div_pending) begin
                div_act <= div_pend;
            end
            // A load landing on the boundary cycle survives for the next boundary.
            if (load_ok) begin
                div_pend    <= div_in;
                div_pending <= 1'b1;
            end else if (boundary) begin
                div_pending <= 1'b0;
            end
        end
    end

`ifdef CLK_DIV_ODD50_EN
    logic q_neg;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            q_neg <= 1'b0;
        end else begin
            q_neg <= hi_q & div_act[0];
        end
    end

    assign clk_out = hi_q | q_neg;
`else
    assign clk_out = hi_q;
`endif

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable integer clock divider FSM producing a divided clock `clk_out` from `clk` for any ratio N in 2..2^DIV_W−1. It generalises the team's fixed divide-by-2 FSM divider with these additions:

- loadable divisor
- enable with glitch-free start/stop
- per-period tick
- optional 50 % duty on odd ratios

It sits in the clock-generation area, feeding slow peripheral clocks and clock enables.

## Interface
- `DIV_W`, default 8: divisor width; max ratio 2^DIV_W−1.
- `DIV_DEFAULT`, default 2: active divisor after reset; must be ≥2.

Ports:
- `clk`  in  1  input clock; sole clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable.
- `div_in`  in  DIV_W  new divisor value.
- `div_load`  in  1  one-cycle strobe; captures `div_in`.
- `clk_out`  out  1  divided clock.
- `tick`  out  1  one-cycle pulse on the first cycle of each HIGH phase.
- `div_pending`  out  1  a loaded divisor is waiting for the next period boundary.
- `load_err`  out  1  one-cycle pulse; rejected load (`div_in` < 2).

## Operation
- FSM states are IDLE, HIGH, LOW. A phase counter of DIV_W bits counts down within HIGH and LOW.
- Registers: active divisor `div_act`, pending divisor `div_pend`, pending flag.
- IDLE:
  - `clk_out`=0.
  - If `en`=1, go to HIGH next cycle and load `div_act` from `div_pend` if pending.
- HIGH:
  - Lasts H = ceil(N/2) cycles, then goes to LOW.
  - `tick`=1 on its first cycle only.
- LOW:
  - Lasts L = floor(N/2) cycles.
  - At the end: if `en`=1, go to HIGH (period boundary, pending divisor applied); else go to IDLE.
- `en` deasserted mid-period: the current period completes (HIGH then LOW) before IDLE. There are no runt pulses.
- `div_load` with `div_in` ≥ 2:
  - `div_pend` ← `div_in`, pending flag set.
  - Multiple loads before a boundary: last one wins.
- `div_load` with `div_in` < 2: ignored; `load_err`=1 for one cycle; pending state unchanged.
- Load in the same cycle as a boundary transition: takes effect at the following boundary. The boundary uses the value registered before that cycle.
- Pending flag clears on the cycle `div_act` is updated.
- `clk_out` is a registered FSM output (state==HIGH), except under the macro below.

## Timing
- Reset values:
  - state IDLE
  - `clk_out`=0, `tick`=0, `load_err`=0, `div_pending`=0
  - `div_act`=`div_pend`=DIV_DEFAULT
  - counter 0
- Start latency: `en` sampled high in IDLE at edge k → `clk_out`=1 and `tick`=1 after edge k+1.
- Period: exactly N `clk` cycles per `clk_out` period while enabled.
- Stop latency: at most N−1 cycles after `en` falls, then IDLE with `clk_out`=0.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous); any pending load is discarded.
- Counter arithmetic: counter loads H−1 or L−1; H and L are computed from `div_act` (shift/add, DIV_W bits, no overflow since N ≤ 2^DIV_W−1).

## Configuration
- Macro: `CLK_DIV_ODD50_EN`.
- Defined:
  - For odd N, HIGH lasts (N−1)/2 cycles.
  - A negedge-clocked flop `q_neg` samples the HIGH flag, and `clk_out` = HIGH flag OR `q_neg`.
  - This gives a high time of N/2 cycles (50 % duty).
  - Even N is unaffected: `q_neg` is gated off.
  - `q_neg` resets to 0.
- Undefined: odd N gives high (N+1)/2 and low (N−1)/2 cycles. No negedge logic; fully single-edge design.

## Structure
- Shared package `clk_div_pkg`:
  - FSM state encoding (IDLE/HIGH/LOW localparams)
  - MIN_DIV=2 constant
  - function computing H/L from N, used for both macro variants
- One natural sub-module, `clk_div_phase_cnt`: loadable down-counter with terminal-count flag, DIV_W wide. Top module holds the FSM, divisor registers and output logic.

## Test plan
- Reset default: `rst` pulse, `en`=1, no load → `clk_out` period 2 cycles, 1 high/1 low, `tick` every 2 cycles; first rise one cycle after `en`.
- Even ratio: load 6 while enabled → after the current period completes, 3 high/3 low, `div_pending` drops at that boundary.
- Odd ratio: load 5 → without macro 3 high/2 low; with `CLK_DIV_ODD50_EN` 2.5 high/2.5 low (check at falling edge).
- Illegal loads: `div_in`=0 then 1 → `load_err` pulses twice, ratio unchanged, `div_pending` stays 0. Two back-to-back legal loads 4 then 7 → ratio 7 applied.
- Stop/restart: N=8, drop `en` 2 cycles into HIGH → remaining 2 HIGH + 4 LOW cycles, then IDLE `clk_out`=0. Raise `en` → restart with `tick` one cycle later.
- Async reset mid-LOW with N=9 and a pending load of 3 → outputs zero immediately; after release, ratio is 2 (DIV_DEFAULT) and the pending value is lost.
